// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared fetch-stage types and constants
// Contents:
//   fetch_state_t : fetch FSM states IDLE/FETCH/HOLD/DISCARD
//   NOP_INSTR     : addi x0,x0,0, the idle value of the decode instruction register
//   fetch_regs_t  : {valid, pc, instr} bundle used for the hold buffer
//   align_pc      : clears the low two bits of a target address
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_regs_t;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - load-enabled register holding the fetch PC
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (resets to RESET_VAL)
//   load       : capture d on the next rising edge
//   d, q       : next value in, current value out
module fetch_pc_reg #(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] RESET_VAL = 32'h0000_0060
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL[WIDTH-1:0];
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch stage with stall hold buffer and redirect squash
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   imem_address, imem_read          : word address (= fetch PC) and read request
//   imem_rdata, imem_resp            : returned word, one-cycle completion strobe
//   stall                            : decode cannot accept, output registers hold
//   redirect, redirect_pc            : taken branch/jump and its target
//   out_valid, out_pc, out_instr     : registered instruction handed to decode
module fetch
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_address,
  output logic        imem_read,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  fetch_state_t state;
  fetch_regs_t  hold_buf;
  logic [31:0]  pending_pc;
  logic [31:0]  pc;
  logic [31:0]  pc_d;
  logic         pc_load;
  logic [31:0]  target;

  assign target       = align_pc(redirect_pc);
  assign imem_address = pc;
  assign imem_read    = (state == FETCH) || (state == DISCARD);

  fetch_pc_reg #(
    .WIDTH     (32),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (pc_load),
    .d     (pc_d),
    .q     (pc)
  );

  // Next PC. A redirect in FETCH without a response must leave the address
  // alone: the outstanding read is still owned by memory until it responds.
  always_comb begin
    pc_load = 1'b0;
    pc_d    = pc + 32'd4;
    case (state)
      IDLE: begin
        if (redirect) begin
          pc_load = 1'b1;
          pc_d    = target;
        end
      end
      FETCH: begin
        if (redirect) begin
          if (imem_resp) begin
            pc_load = 1'b1;
            pc_d    = target;
          end
        end else if (imem_resp) begin
          pc_load = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_load = 1'b1;
          pc_d    = target;
        end
      end
      DISCARD: begin
        if (imem_resp) begin
          pc_load = 1'b1;
          pc_d    = redirect ? target : pending_pc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold_buf   <= '0;
      pending_pc <= '0;
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_instr  <= NOP_INSTR;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          if (redirect || !stall) out_valid <= 1'b0;
        end
        FETCH: begin
          if (redirect) begin
            out_valid <= 1'b0;
            if (!imem_resp) begin
              pending_pc <= target;
              state      <= DISCARD;
            end
          end else if (imem_resp) begin
            if (stall) begin
              hold_buf <= '{valid: 1'b1, pc: pc, instr: imem_rdata};
              state    <= HOLD;
            end else begin
              out_valid <= 1'b1;
              out_pc    <= pc;
              out_instr <= imem_rdata;
            end
          end else if (!stall) begin
            out_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (redirect) begin
            out_valid <= 1'b0;
            hold_buf  <= '0;
            state     <= FETCH;
          end else if (!stall) begin
            out_valid <= hold_buf.valid;
            out_pc    <= hold_buf.pc;
            out_instr <= hold_buf.instr;
            hold_buf  <= '0;
            state     <= FETCH;
          end
        end
        DISCARD: begin
          if (redirect || !stall) out_valid <= 1'b0;
          if (imem_resp) begin
            pending_pc <= '0;
            state      <= FETCH;
          end else if (redirect) begin
            pending_pc <= target;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - directed self-checking bench for the fetch stage
module tb_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_address;
  logic        imem_read;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_resp = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] I0  = 32'h0010_0093;
  localparam logic [31:0] I1  = 32'h0020_0113;
  localparam logic [31:0] I2  = 32'h0030_0193;
  localparam logic [31:0] I3  = 32'h0040_0213;
  localparam logic [31:0] I4  = 32'h0050_0293;
  localparam logic [31:0] BAD = 32'hBAD0_0068;

  fetch #(.RESET_PC(32'h0000_0060)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_address (imem_address),
    .imem_read    (imem_read),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .out_valid    (out_valid),
    .out_pc       (out_pc),
    .out_instr    (out_instr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one response for the edge ahead, then leave the data bus on garbage.
  task automatic resp_cycle(input logic [31:0] data);
    imem_resp  = 1'b1;
    imem_rdata = data;
    tick();
    imem_resp  = 1'b0;
    imem_rdata = BAD;
  endtask

  initial begin
    imem_rdata = BAD;
    tick();
    tick();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_instr", out_instr, 32'h13);
    check("rst_addr", imem_address, 32'h60);
    check("rst_read", {31'd0, imem_read}, 32'd0);

    // Release reset, IDLE -> FETCH
    rst_n = 1'b1;
    tick();
    check("fetch_read", {31'd0, imem_read}, 32'd1);
    check("fetch_addr0", imem_address, 32'h60);

    // Response two cycles after the read for 0x60
    tick();
    check("wait_bubble", {31'd0, out_valid}, 32'd0);
    resp_cycle(I0);
    check("d0_valid", {31'd0, out_valid}, 32'd1);
    check("d0_pc", out_pc, 32'h60);
    check("d0_instr", out_instr, I0);
    check("addr1", imem_address, 32'h64);

    // Stall arrives, response for 0x64 captured into the hold buffer
    stall = 1'b1;
    tick();
    check("stall_hold_valid", {31'd0, out_valid}, 32'd1);
    resp_cycle(I1);
    check("hold_read", {31'd0, imem_read}, 32'd0);
    check("hold_pc", out_pc, 32'h60);
    check("hold_instr", out_instr, I0);
    check("hold_addr", imem_address, 32'h68);
    tick();
    tick();
    check("hold2_read", {31'd0, imem_read}, 32'd0);
    check("hold2_pc", out_pc, 32'h60);
    check("hold2_valid", {31'd0, out_valid}, 32'd1);
    stall = 1'b0;
    tick();
    check("d1_valid", {31'd0, out_valid}, 32'd1);
    check("d1_pc", out_pc, 32'h64);
    check("d1_instr", out_instr, I1);
    check("d1_read", {31'd0, imem_read}, 32'd1);
    check("addr2", imem_address, 32'h68);
    tick();
    check("bubble2", {31'd0, out_valid}, 32'd0);

    // Redirect to 0x200 while 0x68 outstanding -> DISCARD
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    check("disc_addr", imem_address, 32'h68);
    check("disc_read", {31'd0, imem_read}, 32'd1);
    check("disc_valid", {31'd0, out_valid}, 32'd0);
    resp_cycle(BAD);
    check("disc_drop_valid", {31'd0, out_valid}, 32'd0);
    check("disc_drop_instr", out_instr, I1);
    check("redir_addr", imem_address, 32'h200);
    tick();

    // Redirect to 0x303 coincident with a response
    redirect    = 1'b1;
    redirect_pc = 32'h303;
    resp_cycle(BAD);
    redirect = 1'b0;
    check("coinc_addr", imem_address, 32'h300);
    check("coinc_valid", {31'd0, out_valid}, 32'd0);
    check("coinc_instr", out_instr, I1);
    tick();
    resp_cycle(I2);
    check("d2_pc", out_pc, 32'h300);
    check("d2_instr", out_instr, I2);
    check("d2_valid", {31'd0, out_valid}, 32'd1);

    // Redirect beats stall; target 0xFFFFFFFC for the wrap check
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    stall    = 1'b0;
    check("redir_stall_valid", {31'd0, out_valid}, 32'd0);
    check("redir_stall_addr", imem_address, 32'h304);
    resp_cycle(BAD);
    check("wrap_addr0", imem_address, 32'hFFFF_FFFC);
    resp_cycle(I3);
    check("d3_pc", out_pc, 32'hFFFF_FFFC);
    check("d3_instr", out_instr, I3);
    check("wrap_addr", imem_address, 32'h0);

    // Reset mid-read: outputs clear at once, late response ignored in IDLE
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_instr", out_instr, 32'h13);
    check("mid_rst_addr", imem_address, 32'h60);
    check("mid_rst_read", {31'd0, imem_read}, 32'd0);
    tick();
    rst_n = 1'b1;
    resp_cycle(BAD);
    check("late_resp_valid", {31'd0, out_valid}, 32'd0);
    check("late_resp_addr", imem_address, 32'h60);
    check("late_resp_read", {31'd0, imem_read}, 32'd1);
    tick();
    resp_cycle(I4);
    check("restart_pc", out_pc, 32'h60);
    check("restart_instr", out_instr, I4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
